// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Hazard inputs and stage-control outputs of the pipeline sequencer
// Revision : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_is_load;
    logic                  ex_redirect;
    logic                  dmem_req;
    logic                  dmem_ready;
    logic                  md_start;
    logic                  md_done;
    logic                  pc_en;
    logic                  ifid_en;
    logic                  ifid_flush;
    logic                  idex_en;
    logic                  idex_flush;
    logic                  exmem_en;
    logic                  busy;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_redirect, dmem_req, dmem_ready, md_start, md_done,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_redirect, dmem_req, dmem_ready, md_start, md_done,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               busy, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Advance/hold/bubble sequencer for PC, IF/ID, ID/EX and EX/MEM
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  wire               CLK,
    input  wire               RSTN,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [REG_ADDR_W-1:0] c_reg_zero = '0;
    localparam logic [CNT_W-1:0]      c_cnt_max  = '1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MEMW = 2'd1,
        ST_MDW  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_mem_stall;
    logic w_md_stall;
    logic w_eval_md;
    logic w_eval_flow;
    logic w_redirect_taken;
    logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush, w_exmem_en;

    assign w_load_use  = bus.ex_is_load && (bus.ex_rd != c_reg_zero) &&
                         ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                          (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    assign w_mem_stall = bus.dmem_req && !bus.dmem_ready;
    assign w_md_stall  = bus.md_start && !bus.md_done;

    // A freeze release re-enters the RUN priority chain at the rule just below
    // the one that caused the freeze, so deferred hazards are seen exactly once.
    assign w_eval_md   = ((r_state == ST_RUN) && !w_mem_stall) ||
                         ((r_state == ST_MEMW) && bus.dmem_ready);
    assign w_eval_flow = (w_eval_md && !w_md_stall) ||
                         ((r_state == ST_MDW) && bus.md_done);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_pc_en && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect_taken && (r_flush_cnt != c_cnt_max))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_en          = 1'b0;
        w_ifid_en        = 1'b0;
        w_ifid_flush     = 1'b0;
        w_idex_en        = 1'b0;
        w_idex_flush     = 1'b0;
        w_exmem_en       = 1'b0;
        w_redirect_taken = 1'b0;

        if ((r_state == ST_RUN) && w_mem_stall)
            w_state_nxt = ST_MEMW;
        else if (w_eval_md && w_md_stall)
            w_state_nxt = ST_MDW;
        else if (w_eval_flow) begin
            w_state_nxt = ST_RUN;
            if (bus.ex_redirect) begin
                w_pc_en          = 1'b1;
                w_ifid_en        = 1'b1;
                w_ifid_flush     = 1'b1;
                w_idex_en        = 1'b1;
                w_idex_flush     = 1'b1;
                w_exmem_en       = 1'b1;
                w_redirect_taken = 1'b1;
            end else if (w_load_use) begin
                w_idex_en    = 1'b1;
                w_idex_flush = 1'b1;
                w_exmem_en   = 1'b1;
            end else begin
                w_pc_en    = 1'b1;
                w_ifid_en  = 1'b1;
                w_idex_en  = 1'b1;
                w_exmem_en = 1'b1;
            end
        end
    end

    // Reset must quiesce the pipeline immediately, not on the next edge.
    assign bus.pc_en      = RSTN && w_pc_en;
    assign bus.ifid_en    = RSTN && w_ifid_en;
    assign bus.idex_en    = RSTN && w_idex_en;
    assign bus.exmem_en   = RSTN && w_exmem_en;
    assign bus.ifid_flush = !RSTN || w_ifid_flush;
    assign bus.idex_flush = !RSTN || w_idex_flush;
    assign bus.busy       = (r_state != ST_RUN);
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
    logic CLK;
    logic RSTN;
    int   n_checks;
    int   n_fails;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();
    pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  bus_sat ();

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) u_dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus.slave)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) u_dut_sat (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus_sat.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
        bus.ex_rd = '0; bus.ex_is_load = 0; bus.ex_redirect = 0;
        bus.dmem_req = 0; bus.dmem_ready = 0; bus.md_start = 0; bus.md_done = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        bus.ex_is_load = 1; bus.ex_rd = rd; bus.id_use_rs1 = 1; bus.id_rs1 = rd;
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
    function automatic logic [5:0] ctl();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush, bus.exmem_en};
    endfunction

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle_inputs();
        bus_sat.id_rs1 = '0; bus_sat.id_rs2 = '0; bus_sat.id_use_rs1 = 0; bus_sat.id_use_rs2 = 0;
        bus_sat.ex_rd = '0; bus_sat.ex_is_load = 0; bus_sat.ex_redirect = 0;
        bus_sat.dmem_req = 0; bus_sat.dmem_ready = 0; bus_sat.md_start = 0; bus_sat.md_done = 0;

        RSTN = 1'b0;
        #12;
        check_value("reset_ctl", ctl(), 6'b001010);
        check_value("reset_busy", bus.busy, 0);
        check_value("reset_stall_cnt", bus.stall_cnt, 0);
        check_value("reset_flush_cnt", bus.flush_cnt, 0);
        tick();
        RSTN = 1'b1;
        #1;
        check_value("idle_ctl", ctl(), 6'b110101);

        // Load-use on rs1: single bubble
        set_load_use(5'd5);
        #1 check_value("lu_rs1_ctl", ctl(), 6'b000111);
        tick();
        bus.ex_is_load = 0;
        #1 check_value("lu_after_ctl", ctl(), 6'b110101);
        check_value("lu_stall_cnt", bus.stall_cnt, 1);
        tick();

        // Load writing x0 is not a hazard
        set_load_use(5'd0);
        #1 check_value("lu_x0_ctl", ctl(), 6'b110101);
        tick();
        check_value("lu_x0_stall_cnt", bus.stall_cnt, 1);

        // Load-use on rs2
        idle_inputs();
        bus.ex_is_load = 1; bus.ex_rd = 5'd7; bus.id_use_rs2 = 1; bus.id_rs2 = 5'd7;
        bus.id_use_rs1 = 1; bus.id_rs1 = 5'd3;
        #1 check_value("lu_rs2_ctl", ctl(), 6'b000111);
        tick();
        check_value("lu_rs2_stall_cnt", bus.stall_cnt, 2);

        // Redirect overrides a same-cycle load-use
        idle_inputs();
        set_load_use(5'd9);
        bus.ex_redirect = 1;
        #1 check_value("redir_lu_ctl", ctl(), 6'b111111);
        tick();
        check_value("redir_flush_cnt", bus.flush_cnt, 1);
        check_value("redir_stall_cnt", bus.stall_cnt, 2);

        // Memory wait: three wait cycles then ready
        idle_inputs();
        bus.dmem_req = 1;
        #1 check_value("memw_c1_ctl", ctl(), 6'b000000);
        check_value("memw_c1_busy", bus.busy, 0);
        tick();
        check_value("memw_c2_ctl", ctl(), 6'b000000);
        check_value("memw_c2_busy", bus.busy, 1);
        tick();
        check_value("memw_c3_ctl", ctl(), 6'b000000);
        check_value("memw_c3_busy", bus.busy, 1);
        tick();
        bus.dmem_ready = 1;
        #1 check_value("memw_rdy_ctl", ctl(), 6'b110101);
        tick();
        check_value("memw_end_busy", bus.busy, 0);
        check_value("memw_stall_cnt", bus.stall_cnt, 5);

        // Multi-cycle op with a redirect held behind the freeze
        idle_inputs();
        bus.md_start = 1; bus.ex_redirect = 1;
        #1 check_value("md_c1_ctl", ctl(), 6'b000000);
        tick();
        bus.md_start = 0;
        for (int i = 2; i <= 4; i++) begin
            #1 check_value($sformatf("md_c%0d_ctl", i), ctl(), 6'b000000);
            check_value($sformatf("md_c%0d_busy", i), bus.busy, 1);
            tick();
        end
        bus.md_done = 1;
        #1 check_value("md_done_ctl", ctl(), 6'b111111);
        tick();
        check_value("md_flush_cnt", bus.flush_cnt, 2);
        check_value("md_stall_cnt", bus.stall_cnt, 9);
        check_value("md_end_busy", bus.busy, 0);

        // Single-cycle md op
        idle_inputs();
        bus.md_start = 1; bus.md_done = 1;
        #1 check_value("md_1cyc_ctl", ctl(), 6'b110101);
        tick();
        check_value("md_1cyc_busy", bus.busy, 0);
        check_value("md_1cyc_stall_cnt", bus.stall_cnt, 9);

        // Memory release straight into a multi-cycle freeze
        idle_inputs();
        bus.dmem_req = 1;
        tick();
        bus.dmem_ready = 1; bus.md_start = 1;
        #1 check_value("memw_to_md_ctl", ctl(), 6'b000000);
        tick();
        bus.dmem_req = 0; bus.dmem_ready = 0; bus.md_start = 0;
        #1 check_value("memw_to_md_busy", bus.busy, 1);

        // Reset during the freeze
        RSTN = 1'b0;
        #1 check_value("rst_mid_ctl", ctl(), 6'b001010);
        check_value("rst_mid_busy", bus.busy, 0);
        check_value("rst_mid_stall_cnt", bus.stall_cnt, 0);
        check_value("rst_mid_flush_cnt", bus.flush_cnt, 0);
        tick();
        RSTN = 1'b1;
        #1 check_value("post_rst_ctl", ctl(), 6'b110101);
        tick();
        check_value("post_rst_busy", bus.busy, 0);
        check_value("post_rst_stall_cnt", bus.stall_cnt, 0);

        // Saturation on the narrow-counter instance
        bus_sat.dmem_req = 1;
        for (int i = 0; i < 14; i++) tick();
        check_value("sat_cnt_14", bus_sat.stall_cnt, 14);
        for (int i = 0; i < 6; i++) tick();
        check_value("sat_cnt_20", bus_sat.stall_cnt, 15);
        check_value("sat_pc_en", bus_sat.pc_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register.
- Decides each cycle whether each stage advances, holds or is replaced by a bubble.
- Stall sources: load-use hazards, branch/jal redirects, data-memory wait states and multi-cycle EX operations (mul/div).
- Keeps saturating performance counters of stall and flush cycles.

Parameters:
REG_ADDR_W, 5, width of register index fields
CNT_W, 32, width of performance counters

Ports:
CLK  in  1  clock, all state updates on rising edge
RSTN  in  1  asynchronous active-low reset
id_rs1  in  REG_ADDR_W  rs1 index of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 index of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  destination index of instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved taken branch/jal/jalr (new PC valid this cycle)
dmem_req  in  1  memory stage issuing access this cycle
dmem_ready  in  1  memory access completes this cycle
md_start  in  1  EX holds a multi-cycle op starting this cycle
md_done  in  1  multi-cycle unit result valid this cycle
pc_en  out  1  PC register loads next value
ifid_en  out  1  IF/ID register loads
ifid_flush  out  1  IF/ID loads a bubble (overrides ifid_en)
idex_en  out  1  ID/EX register loads
idex_flush  out  1  ID/EX loads a bubble (overrides idex_en)
exmem_en  out  1  EX/MEM register loads
busy  out  1  state is MEMW or MDW
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Control outputs are combinational from state and inputs. State and counters are registered.
- While RSTN=0:
  - all *_en = 0, both flushes = 1, busy = 0.
  - state = RUN, counters = 0.
  - Reset mid-stall abandons the stall immediately.
- load_use = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- mem_stall = dmem_req & !dmem_ready.
- States: RUN, MEMW, MDW.
- RUN, evaluated in priority order:
  1. mem_stall: all enables 0, no flush; next state MEMW.
  2. md_start & !md_done: all enables 0; next state MDW. md_start & md_done in the same cycle counts as a single-cycle op and does not stall.
  3. ex_redirect: all enables 1, ifid_flush = 1, idex_flush = 1. load_use is ignored because the ID instruction is wrong-path.
  4. load_use: pc_en = 0, ifid_en = 0, idex_en = 1 with idex_flush = 1 (bubble), exmem_en = 1. Lasts exactly one cycle, since the bubble clears the hazard.
  5. Otherwise: all enables 1, no flush.
- MEMW:
  - While !dmem_ready: all enables 0.
  - When dmem_ready: apply RUN rules 2-5 in the same cycle and return to RUN, or go to MDW if rule 2 fires.
- MDW:
  - While !md_done: all enables 0, ignoring ex_redirect and load_use; the EX instruction is held.
  - When md_done: apply RUN rules 3-5, then return to RUN.
- A redirect or load-use pending behind a freeze is therefore taken exactly once, on the release cycle.
- busy = (state != RUN).
- stall_cnt increments each cycle pc_en=0 with RSTN=1. flush_cnt increments each cycle ex_redirect takes effect.
- Both counters saturate at all-ones and never wrap.
- No input is registered; latency from input to control output is 0 cycles.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_use_rs1=1, id_rs1=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; next cycle (ex_is_load=0) all enables 1; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Redirect plus load-use same cycle -> ifid_flush=1, idex_flush=1, pc_en=1, no stall; flush_cnt=1.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> enables 0 for 3 cycles, busy=1 for cycles 2-3, enables 1 on the ready cycle; stall_cnt=3.
- Mul/div: md_start=1, md_done=0, then md_done after 4 cycles with ex_redirect=1 held -> freeze until done; on the done cycle pc_en=1 and both flushes 1; flush_cnt=1. Also md_start=md_done=1 in one cycle -> no stall.
- Reset mid-MDW: drop RSTN during the freeze -> immediately enables 0, flushes 1, counters 0; after release, state RUN with normal flow.
- Saturation: preload stall_cnt to all-ones via forced stalls (CNT_W=4 instance, 20 stall cycles) -> stall_cnt holds 15.
